// File: rtl/alu.sv
// Registered ALU: add/sub, signed compares, bitwise logic and shifts, result on Y one cycle later.
// Defining ALU_MUL_EN adds a low-half multiply on ALUFN 100010; otherwise that code yields zero.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       ALUFN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100001;
    localparam logic [5:0] OP_MUL   = 6'b100010;
    localparam logic [5:0] OP_CMPEQ = 6'b100100;
    localparam logic [5:0] OP_CMPLT = 6'b100101;
    localparam logic [5:0] OP_CMPLE = 6'b100110;
    localparam logic [5:0] OP_AND   = 6'b101000;
    localparam logic [5:0] OP_OR    = 6'b101001;
    localparam logic [5:0] OP_XOR   = 6'b101010;
    localparam logic [5:0] OP_XNOR  = 6'b101011;
    localparam logic [5:0] OP_SHL   = 6'b101100;
    localparam logic [5:0] OP_SHR   = 6'b101101;
    localparam logic [5:0] OP_SRA   = 6'b101110;

    logic [SHW-1:0]   shamt;
    logic             lt_signed;
    logic             eq;
    logic [WIDTH-1:0] result;

    // Only the low bits of B select the shift distance; the rest are ignored.
    assign shamt     = B[SHW-1:0];
    assign lt_signed = $signed(A) < $signed(B);
    assign eq        = (A == B);

    always_comb begin
        result = '0;
        unique case (ALUFN)
            OP_ADD:   result = A + B;
            OP_SUB:   result = A - B;
`ifdef ALU_MUL_EN
            OP_MUL:   result = A * B;
`endif
            OP_CMPEQ: result = {{(WIDTH-1){1'b0}}, eq};
            OP_CMPLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_CMPLE: result = {{(WIDTH-1){1'b0}}, lt_signed | eq};
            OP_AND:   result = A & B;
            OP_OR:    result = A | B;
            OP_XOR:   result = A ^ B;
            OP_XNOR:  result = ~(A ^ B);
            OP_SHL:   result = A << shamt;
            OP_SHR:   result = A >> shamt;
            OP_SRA:   result = $unsigned($signed(A) >>> shamt);
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y <= '0;
        end else begin
            Y <= result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every listed operation, boundaries and unused codes.
module tb_alu;

    localparam int W = 32;

    localparam logic [5:0] ADD   = 6'b100000;
    localparam logic [5:0] SUB   = 6'b100001;
    localparam logic [5:0] MUL   = 6'b100010;
    localparam logic [5:0] CMPEQ = 6'b100100;
    localparam logic [5:0] CMPLT = 6'b100101;
    localparam logic [5:0] CMPLE = 6'b100110;
    localparam logic [5:0] AND_  = 6'b101000;
    localparam logic [5:0] OR_   = 6'b101001;
    localparam logic [5:0] XOR_  = 6'b101010;
    localparam logic [5:0] XNOR_ = 6'b101011;
    localparam logic [5:0] SHL   = 6'b101100;
    localparam logic [5:0] SHR   = 6'b101101;
    localparam logic [5:0] SRA   = 6'b101110;

    logic         clk;
    logic         rst_n;
    logic [5:0]   alufn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;

    int n_checks = 0;
    int n_errors = 0;

    alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ALUFN(alufn),
        .A    (a),
        .B    (b),
        .Y    (y)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge capture, sample 1ns later.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp);
        @(negedge clk);
        alufn = fn;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        check(tag, y, exp);
    endtask

    initial begin
        logic [W-1:0] mul_exp;
        rst_n = 1'b0;
        alufn = ADD;
        a     = 32'd15;
        b     = 32'd13;

        // Reset held for two edges with a live ADD on the inputs.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_y", y, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_add", y, 32'd28);
        // Result must hold until the next edge.
        @(negedge clk);
        alufn = SUB;
        #2;
        check("hold_y", y, 32'd28);

        run_op("cmpeq_15_13", CMPEQ, 32'd15, 32'd13, 32'd0);
        run_op("cmpeq_13_13", CMPEQ, 32'd13, 32'd13, 32'd1);
        run_op("cmpeq_13_15", CMPEQ, 32'd13, 32'd15, 32'd0);
        run_op("cmplt_15_13", CMPLT, 32'd15, 32'd13, 32'd0);
        run_op("cmplt_13_13", CMPLT, 32'd13, 32'd13, 32'd0);
        run_op("cmplt_13_15", CMPLT, 32'd13, 32'd15, 32'd1);
        run_op("cmple_15_13", CMPLE, 32'd15, 32'd13, 32'd0);
        run_op("cmple_13_13", CMPLE, 32'd13, 32'd13, 32'd1);
        run_op("cmple_13_15", CMPLE, 32'd13, 32'd15, 32'd1);

        run_op("and",  AND_,  32'd15, 32'd13, 32'd13);
        run_op("or",   OR_,   32'd15, 32'd13, 32'd15);
        run_op("xor",  XOR_,  32'd15, 32'd13, 32'd2);
        run_op("xnor", XNOR_, 32'd15, 32'd13, 32'hFFFF_FFFD);
        run_op("sub_pos", SUB, 32'd15, 32'd13, 32'd2);
        run_op("sub_neg", SUB, 32'd13, 32'd15, 32'hFFFF_FFFE);
        run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        run_op("logic_mix_and", AND_, 32'hA5A5_F00F, 32'h0FF0_3C3C, 32'h05A0_300C);
        run_op("logic_mix_or",  OR_,  32'hA5A5_F00F, 32'h0FF0_3C3C, 32'hAFF5_FC3F);

        run_op("shl_4",    SHL, 32'd15, 32'd4, 32'd240);
        run_op("shr_4",    SHR, 32'd15, 32'd4, 32'd0);
        run_op("sra_neg",  SRA, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF);
        run_op("shr_neg",  SHR, 32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF);
        run_op("shl_b24",  SHL, 32'd15, 32'h24, 32'd240);
        run_op("sra_b24",  SRA, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000);
        run_op("sra_pos",  SRA, 32'h7000_0000, 32'd4, 32'h0700_0000);
        run_op("shl_0",    SHL, 32'h1234_5678, 32'h20, 32'h1234_5678);
        run_op("shr_31",   SHR, 32'h8000_0000, 32'd31, 32'd1);
        run_op("sra_31",   SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        run_op("shl_31",   SHL, 32'd3, 32'd31, 32'h8000_0000);

        run_op("cmplt_ovf", CMPLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        run_op("cmple_ovf", CMPLE, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        run_op("cmplt_ovf_rev", CMPLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("cmplt_m1_0", CMPLT, 32'hFFFF_FFFF, 32'd0, 32'd1);

        run_op("op_000000", 6'b000000, 32'd15, 32'd13, 32'd0);
        run_op("op_101111", 6'b101111, 32'd15, 32'd13, 32'd0);
        run_op("op_100011", 6'b100011, 32'd15, 32'd13, 32'd0);
        run_op("op_100111", 6'b100111, 32'd15, 32'd13, 32'd0);
        run_op("op_111111", 6'b111111, 32'd15, 32'd13, 32'd0);
        run_op("op_001000", 6'b001000, 32'd15, 32'd13, 32'd0);

`ifdef ALU_MUL_EN
        mul_exp = 32'h0001_0000;
`else
        mul_exp = 32'd0;
`endif
        run_op("mul", MUL, 32'h0001_0000, 32'h0001_0001, mul_exp);

        // Mid-stream reset: one reset edge, then results resume with no warm-up.
        run_op("pre_rst", ADD, 32'd100, 32'd23, 32'd123);
        @(negedge clk);
        rst_n = 1'b0;
        alufn = OR_;
        a     = 32'hFFFF_FFFF;
        b     = 32'd0;
        @(posedge clk);
        #1;
        check("mid_rst_y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_or", y, 32'hFFFF_FFFF);
        run_op("post_rst_xor", XOR_, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
